// File: rtl/parity_rx4_if.sv
// rtl/parity_rx4_if.sv - serial line and frame-result bundle for the 4-bit parity receiver
interface parity_rx4_if;
  logic       rx;
  logic [3:0] data_o;
  logic [4:0] cw_o;
  logic       valid_o;
  logic       parity_err_o;
  logic       frame_err_o;
  logic       busy_o;

  // master is the receiver producing results; slave drives the line and consumes results
  modport master (
    input  rx,
    output data_o,
    output cw_o,
    output valid_o,
    output parity_err_o,
    output frame_err_o,
    output busy_o
  );

  modport slave (
    output rx,
    input  data_o,
    input  cw_o,
    input  valid_o,
    input  parity_err_o,
    input  frame_err_o,
    input  busy_o
  );
endinterface

// File: rtl/parity_rx4.sv
// rtl/parity_rx4.sv - framed serial receiver with 4-bit data and even-parity check
module parity_rx4 #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  parity_rx4_if.master bus
);

  localparam int H  = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(H - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t state, state_nxt;

  logic          rx_m, rx_s;
  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [3:0]    shift;
  logic          p;

  logic          cnt_clr, cnt_inc, idx_clr, idx_inc, shift_en, p_en, done;

  logic [3:0]    data_r;
  logic [4:0]    cw_r;
  logic          valid_r, parity_err_r, frame_err_r;

  // Line is asynchronous; both flops reset to the idle level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= bus.rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    idx_clr   = 1'b0;
    idx_inc   = 1'b0;
    shift_en  = 1'b0;
    p_en      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rx_s) begin
          state_nxt = S_START;
          cnt_clr   = 1'b1;
        end
      end
      S_START: begin
        // Mid-bit recheck rejects glitches shorter than half a bit.
        if (cnt == CNT_MID) begin
          cnt_clr   = 1'b1;
          idx_clr   = 1'b1;
          state_nxt = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_DATA: begin
        if (cnt == CNT_LAST) begin
          shift_en = 1'b1;
          cnt_clr  = 1'b1;
          if (idx == 2'd3) begin
            state_nxt = S_PARITY;
          end else begin
            idx_inc = 1'b1;
          end
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_PARITY: begin
        if (cnt == CNT_LAST) begin
          p_en      = 1'b1;
          cnt_clr   = 1'b1;
          state_nxt = S_STOP;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_STOP: begin
        if (cnt == CNT_LAST) begin
          done      = 1'b1;
          cnt_clr   = 1'b1;
          state_nxt = rx_s ? S_IDLE : S_BREAK;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_BREAK: begin
        // A held-low line must return high before another start bit counts.
        if (rx_s) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
      p     <= 1'b0;
    end else begin
      if (cnt_clr) begin
        cnt <= '0;
      end else if (cnt_inc) begin
        cnt <= cnt + 1'b1;
      end
      if (idx_clr) begin
        idx <= '0;
      end else if (idx_inc) begin
        idx <= idx + 1'b1;
      end
      if (shift_en) begin
        shift[idx] <= rx_s;
      end
      if (p_en) begin
        p <= rx_s;
      end
    end
  end

  // Results hold until the next completed frame, errored or not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r       <= '0;
      cw_r         <= '0;
      valid_r      <= 1'b0;
      parity_err_r <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      valid_r <= done;
      if (done) begin
        data_r       <= shift;
        cw_r         <= {p, shift};
        parity_err_r <= ^{p, shift};
        frame_err_r  <= ~rx_s;
      end
    end
  end

  assign bus.data_o       = data_r;
  assign bus.cw_o         = cw_r;
  assign bus.valid_o      = valid_r;
  assign bus.parity_err_o = parity_err_r;
  assign bus.frame_err_o  = frame_err_r;
  assign bus.busy_o       = (state != S_IDLE);

endmodule
